muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle sequencer/executor for RV32M ops flagged by the decoder (mul_inst/div_inst, mulsel, divsel).
//  Sits beside the EX-stage ALU: accepts one op, holds the pipeline via md_stall, then returns the result
//  with rd for writeback. Owns a MUL_LAT-cycle multiplier and a radix-2 restoring divider; one op in flight.
// PARAMETERS
//  XLEN     32  operand/result width (only 32 supported)
//  MUL_LAT  2   cycles spent in MUL state, legal 1..8
// PORTS
//  clk              in   1     system clock, rising edge
//  rst_n            in   1     asynchronous active-low reset
//  mul_inst         in   1     EX-stage op is MUL*; qualified by mulsel
//  div_inst         in   1     EX-stage op is DIV*/REM*; qualified by divsel
//  mulsel           in   3     001 mul, 010 mulh, 011 mulhsu, 100 mulhu
//  divsel           in   3     001 div, 010 divu, 011 rem, 100 remu
//  rs1_data         in   XLEN  dividend / multiplicand
//  rs2_data         in   XLEN  divisor / multiplier
//  rd_in            in   5     destination register of the op
//  flush            in   1     pipeline flush; cancels op in flight
//  md_stall         out  1     hold IF/ID/EX while op executes
//  md_busy          out  1     state != IDLE
//  md_result_valid  out  1     one-cycle pulse, md_result/md_rd valid
//  md_result        out  XLEN  result
//  md_rd            out  5     destination register for md_result
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, counter 0, all registers 0; md_stall=0 (comb: no op presented, see below),
//    md_busy=0, md_result_valid=0, md_result=0, md_rd=0. Reset mid-op discards it, no result.
//  - States IDLE, MUL, DIV, DONE. start = IDLE & (mul_inst|div_inst) & !flush. Both inst set: mul wins.
//  - IDLE->MUL on start&mul_inst: latch operands, mulsel, rd; cnt=MUL_LAT-1. MUL: cnt--, at 0 -> DONE.
//  - IDLE->DIV on start&div_inst: latch; div-by-zero or (div/rem, rs1=0x80000000, rs2=-1) -> DONE directly.
//    Else cnt=31, 32 restoring iterations on magnitudes (signed ops) or raw values (unsigned), then DONE.
//  - DONE -> IDLE unconditionally; md_result_valid = (state==DONE) & !flush.
//  - md_stall (comb) = start | state==MUL | state==DIV. Deasserted in DONE so the op advances with its result.
//  - Latency from accept cycle 0: mul result in cycle MUL_LAT+1; normal div in cycle 33; special div cycle 1.
//  - Results: mul low 32 bits; mulh/mulhsu/mulhu upper 32 of 64-bit product with ss/su/uu signedness.
//    div: quotient negated if signs differ; rem takes dividend sign. /0: q=0xFFFFFFFF, r=rs1.
//    Overflow (-2^31 / -1): q=0x80000000, r=0. All arithmetic modulo 2^32.
//  - Flush in MUL/DIV: -> IDLE next edge, no valid pulse. Flush in DONE: pulse suppressed, ->IDLE.
//    Flush in IDLE blocks start that cycle.
//  - New op presented while busy is ignored (pipeline is stalled; decoder holds it).
//  - md_result/md_rd hold last value between pulses; mulsel/divsel other than listed codes: no start.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined: non-special div with |rs1| < |rs2| (unsigned compare of magnitudes)
//    goes IDLE->DONE with q=0, r=rs1 (result in cycle 1).
//  Not defined: such ops run full 32 iterations; results identical, only latency differs.
// TESTING
//  mul 7*-3 (mulsel=001), MUL_LAT=2 -> md_stall cycles 0-2, valid cycle 3, result 0xFFFFFFEB, md_rd=rd_in.
//  mulhu 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; mulhsu -1*0xFFFFFFFF -> 0xFFFFFFFF.
//  div -7/2 -> 0xFFFFFFFD in cycle 33; rem -7/2 -> 0xFFFFFFFF; divu 100/0 -> 0xFFFFFFFF cycle 1; remu 100/0 -> 100.
//  div 0x80000000/-1 -> 0x80000000, rem -> 0, both valid cycle 1, no iteration.
//  flush at cycle 10 of a div -> IDLE cycle 11, no valid pulse, md_stall low; next mul accepted normally.
//  rst_n low mid-div -> all outputs 0 immediately; div 3/5 with MULDIV_EARLY_OUT_EN -> q=0 cycle 1, else cycle 33.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M executor beside the EX-stage ALU.
// Accepts one MUL*/DIV*/REM* op, stalls the pipeline while it runs and
// returns the result with its rd as a one-cycle valid pulse. The multiplier
// result is taken after MUL_LAT cycles; division is a radix-2 restoring loop
// on operand magnitudes.
// Optional feature: define MULDIV_EARLY_OUT_EN to finish divisions with
// |dividend| < |divisor| right after accept (q=0, r=dividend).
module muldiv_sequencer #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mul_inst,
  input  logic            div_inst,
  input  logic [2:0]      mulsel,
  input  logic [2:0]      divsel,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            md_stall,
  output logic            md_busy,
  output logic            md_result_valid,
  output logic [XLEN-1:0] md_result,
  output logic [4:0]      md_rd
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [2:0] MSEL_MUL    = 3'b001;
  localparam logic [2:0] MSEL_MULH   = 3'b010;
  localparam logic [2:0] MSEL_MULHSU = 3'b011;
  localparam logic [2:0] MSEL_MULHU  = 3'b100;
  localparam logic [2:0] DSEL_DIV    = 3'b001;
  localparam logic [2:0] DSEL_DIVU   = 3'b010;
  localparam logic [2:0] DSEL_REM    = 3'b011;
  localparam logic [2:0] DSEL_REMU   = 3'b100;

  localparam logic [4:0]      MUL_CNT_INIT = 5'(MUL_LAT - 1);
  localparam logic [4:0]      DIV_CNT_INIT = 5'(XLEN - 1);
  localparam logic [XLEN-1:0] ZERO_W       = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES_W       = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_W        = {1'b1, {(XLEN-1){1'b0}}};

  // State and datapath registers
  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   a_q, a_d;          // multiplicand, or dividend shifting into quotient
  logic [XLEN-1:0]   b_q, b_d;          // multiplier, or divisor magnitude
  logic [XLEN-1:0]   rem_q, rem_d;      // partial remainder
  logic [2:0]        sel_q, sel_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   res_q, res_d;      // result of the op in DONE
  logic [XLEN-1:0]   last_res_q, last_res_d;
  logic [4:0]        last_rd_q, last_rd_d;

  // Combinational helpers
  logic              mul_sel_ok_s, div_sel_ok_s;
  logic              go_mul_s, go_div_s, start_s;
  logic              div_signed_s, div_is_rem_in_s;
  logic              rs1_neg_s, rs2_neg_s;
  logic [XLEN-1:0]   rs1_mag_s, rs2_mag_s;
  logic              div_zero_s, div_ovf_s;
  logic [XLEN-1:0]   special_res_s;
`ifdef MULDIV_EARLY_OUT_EN
  logic              early_out_s;
  logic [XLEN-1:0]   early_res_s;
`endif
  logic              mul_a_signed_s, mul_b_signed_s;
  logic [2*XLEN-1:0] mul_a_ext_s, mul_b_ext_s, mul_prod_s;
  logic [XLEN-1:0]   mul_res_s;
  logic [XLEN:0]     rem_sh_s, rem_diff_s;
  logic              quo_bit_s;
  logic [XLEN-1:0]   rem_nx_s, quo_nx_s;
  logic [XLEN-1:0]   quo_fin_s, rem_fin_s, div_res_s;
  logic              div_is_rem_q_s;

  // Qualify a newly presented op; mul wins when both are flagged
  always_comb begin
    mul_sel_ok_s = (mulsel == MSEL_MUL) || (mulsel == MSEL_MULH) ||
                   (mulsel == MSEL_MULHSU) || (mulsel == MSEL_MULHU);
    div_sel_ok_s = (divsel == DSEL_DIV) || (divsel == DSEL_DIVU) ||
                   (divsel == DSEL_REM) || (divsel == DSEL_REMU);
    go_mul_s     = mul_inst && mul_sel_ok_s;
    go_div_s     = div_inst && div_sel_ok_s && !mul_inst;
    start_s      = (state_q == ST_IDLE) && !flush && (go_mul_s || go_div_s);
  end

  // Divider operand preparation and special-case results at accept time
  always_comb begin
    div_signed_s    = (divsel == DSEL_DIV) || (divsel == DSEL_REM);
    div_is_rem_in_s = (divsel == DSEL_REM) || (divsel == DSEL_REMU);
    rs1_neg_s       = div_signed_s && rs1_data[XLEN-1];
    rs2_neg_s       = div_signed_s && rs2_data[XLEN-1];
    if (rs1_neg_s) begin
      rs1_mag_s = ZERO_W - rs1_data;
    end else begin
      rs1_mag_s = rs1_data;
    end
    if (rs2_neg_s) begin
      rs2_mag_s = ZERO_W - rs2_data;
    end else begin
      rs2_mag_s = rs2_data;
    end
    div_zero_s = (rs2_data == ZERO_W);
    div_ovf_s  = div_signed_s && (rs1_data == MIN_W) && (rs2_data == ONES_W);
    if (div_zero_s) begin
      special_res_s = div_is_rem_in_s ? rs1_data : ONES_W;
    end else if (div_ovf_s) begin
      special_res_s = div_is_rem_in_s ? ZERO_W : MIN_W;
    end else begin
      special_res_s = ZERO_W;
    end
`ifdef MULDIV_EARLY_OUT_EN
    early_out_s = (rs1_mag_s < rs2_mag_s);
    early_res_s = div_is_rem_in_s ? rs1_data : ZERO_W;
`endif
  end

  // Multiplier: sign-extend latched operands per variant, take low or high word
  always_comb begin
    mul_a_signed_s = (sel_q == MSEL_MULH) || (sel_q == MSEL_MULHSU);
    mul_b_signed_s = (sel_q == MSEL_MULH);
    mul_a_ext_s    = {{XLEN{mul_a_signed_s & a_q[XLEN-1]}}, a_q};
    mul_b_ext_s    = {{XLEN{mul_b_signed_s & b_q[XLEN-1]}}, b_q};
    mul_prod_s     = mul_a_ext_s * mul_b_ext_s;
    if (sel_q == MSEL_MUL) begin
      mul_res_s = mul_prod_s[XLEN-1:0];
    end else begin
      mul_res_s = mul_prod_s[2*XLEN-1:XLEN];
    end
  end

  // One restoring-division step plus sign fix-up of the final quotient/remainder
  always_comb begin
    rem_sh_s   = {rem_q, a_q[XLEN-1]};
    rem_diff_s = rem_sh_s - {1'b0, b_q};
    quo_bit_s  = !rem_diff_s[XLEN];
    if (quo_bit_s) begin
      rem_nx_s = rem_diff_s[XLEN-1:0];
    end else begin
      rem_nx_s = rem_sh_s[XLEN-1:0];
    end
    quo_nx_s  = {a_q[XLEN-2:0], quo_bit_s};
    quo_fin_s = neg_quo_q ? (ZERO_W - quo_nx_s) : quo_nx_s;
    rem_fin_s = neg_rem_q ? (ZERO_W - rem_nx_s) : rem_nx_s;
    div_is_rem_q_s = (sel_q == DSEL_REM) || (sel_q == DSEL_REMU);
    if (div_is_rem_q_s) begin
      div_res_s = rem_fin_s;
    end else begin
      div_res_s = quo_fin_s;
    end
  end

  // Next-state and output logic of the sequencer FSM
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    a_d             = a_q;
    b_d             = b_q;
    rem_d           = rem_q;
    sel_d           = sel_q;
    rd_d            = rd_q;
    neg_quo_d       = neg_quo_q;
    neg_rem_d       = neg_rem_q;
    res_d           = res_q;
    last_res_d      = last_res_q;
    last_rd_d       = last_rd_q;
    md_result_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          rd_d = rd_in;
          if (go_mul_s) begin
            state_d = ST_MUL;
            a_d     = rs1_data;
            b_d     = rs2_data;
            sel_d   = mulsel;
            cnt_d   = MUL_CNT_INIT;
          end else begin
            sel_d = divsel;
            if (div_zero_s || div_ovf_s) begin
              state_d = ST_DONE;
              res_d   = special_res_s;
            end
`ifdef MULDIV_EARLY_OUT_EN
            else if (early_out_s) begin
              state_d = ST_DONE;
              res_d   = early_res_s;
            end
`endif
            else begin
              state_d   = ST_DIV;
              a_d       = rs1_mag_s;
              b_d       = rs2_mag_s;
              rem_d     = ZERO_W;
              cnt_d     = DIV_CNT_INIT;
              neg_quo_d = rs1_neg_s ^ rs2_neg_s;
              neg_rem_d = rs1_neg_s;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 5'd0) begin
          state_d = ST_DONE;
          res_d   = mul_res_s;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_DIV: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          a_d   = quo_nx_s;
          rem_d = rem_nx_s;
          if (cnt_q == 5'd0) begin
            state_d = ST_DONE;
            res_d   = div_res_s;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (!flush) begin
          md_result_valid = 1'b1;
          last_res_d      = res_q;
          last_rd_d       = rd_q;
        end else begin
          md_result_valid = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pipeline hold and busy indication
  always_comb begin
    md_stall = start_s || (state_q == ST_MUL) || (state_q == ST_DIV);
    md_busy  = (state_q != ST_IDLE);
  end

  // Result port: fresh value during the pulse, otherwise the last delivered one
  always_comb begin
    if (md_result_valid) begin
      md_result = res_q;
      md_rd     = rd_q;
    end else begin
      md_result = last_res_q;
      md_rd     = last_rd_q;
    end
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 5'd0;
      a_q        <= ZERO_W;
      b_q        <= ZERO_W;
      rem_q      <= ZERO_W;
      sel_q      <= 3'b000;
      rd_q       <= 5'd0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      res_q      <= ZERO_W;
      last_res_q <= ZERO_W;
      last_rd_q  <= 5'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rem_q      <= rem_d;
      sel_q      <= sel_d;
      rd_q       <= rd_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      res_q      <= res_d;
      last_res_q <= last_res_d;
      last_rd_q  <= last_rd_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (MUL_LAT=2).
// Honours MULDIV_EARLY_OUT_EN for the expected latency of small divisions.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mul_inst, div_inst, flush;
  logic [2:0]  mulsel, divsel;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_in;
  logic        md_stall, md_busy, md_result_valid;
  logic [31:0] md_result;
  logic [4:0]  md_rd;

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int SMALL_DIV_LAT = 1;
`else
  localparam int SMALL_DIV_LAT = 33;
`endif

  muldiv_sequencer #(.XLEN(32), .MUL_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .mul_inst(mul_inst), .div_inst(div_inst),
    .mulsel(mulsel), .divsel(divsel), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rd_in(rd_in), .flush(flush), .md_stall(md_stall), .md_busy(md_busy),
    .md_result_valid(md_result_valid), .md_result(md_result), .md_rd(md_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present an op at cycle 0 and hold it until the valid pulse (or timeout).
  // Returns pulse cycle (-1 on timeout), result, rd and number of stalled cycles.
  task automatic run_op(input logic m, input logic d, input logic [2:0] ms, input logic [2:0] ds,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] r,
                        output int lat, output logic [31:0] res, output logic [4:0] rdo,
                        output int nstall);
    mul_inst = m; div_inst = d; mulsel = ms; divsel = ds;
    rs1_data = a; rs2_data = b; rd_in = r;
    lat = -1; res = 32'd0; rdo = 5'd0; nstall = 0;
    #1;
    for (int c = 0; c < 60; c++) begin
      if (md_stall) nstall++;
      if (md_result_valid) begin
        lat = c; res = md_result; rdo = md_rd;
        break;
      end
      @(posedge clk); #1;
    end
    mul_inst = 1'b0; div_inst = 1'b0; mulsel = 3'b000; divsel = 3'b000;
    @(posedge clk); #1;
  endtask

  int          lat, nst, pulses;
  logic [31:0] res;
  logic [4:0]  rdo;

  initial begin
    rst_n = 1'b0; mul_inst = 1'b0; div_inst = 1'b0; flush = 1'b0;
    mulsel = 3'b000; divsel = 3'b000; rs1_data = 32'd0; rs2_data = 32'd0; rd_in = 5'd0;
    #3;
    chk("rst_stall", md_stall, 32'd0);
    chk("rst_busy", md_busy, 32'd0);
    chk("rst_valid", md_result_valid, 32'd0);
    chk("rst_result", md_result, 32'd0);
    chk("rst_rd", md_rd, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // mul 7 * -3
    run_op(1'b1, 1'b0, 3'b001, 3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, lat, res, rdo, nst);
    chk("mul_lat", lat, 32'd3);
    chk("mul_res", res, 32'hFFFFFFEB);
    chk("mul_rd", rdo, 32'd5);
    chk("mul_stall_cycles", nst, 32'd3);
    chk("hold_res", md_result, 32'hFFFFFFEB);
    chk("hold_busy", md_busy, 32'd0);

    // flush in DONE: no pulse, previous result held
    mul_inst = 1'b1; mulsel = 3'b001; rs1_data = 32'd2; rs2_data = 32'd3; rd_in = 5'd9;
    #1 chk("fdone_stall0", md_stall, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1 flush = 1'b1; mul_inst = 1'b0;
    #1;
    chk("fdone_busy", md_busy, 32'd1);
    chk("fdone_valid", md_result_valid, 32'd0);
    chk("fdone_res", md_result, 32'hFFFFFFEB);
    chk("fdone_rd", md_rd, 32'd5);
    @(posedge clk); #1 flush = 1'b0;
    chk("fdone_idle", md_busy, 32'd0);

    // flush in IDLE blocks start; unlisted select codes never start
    mul_inst = 1'b1; mulsel = 3'b001; flush = 1'b1;
    #1 chk("fidle_stall", md_stall, 32'd0);
    @(posedge clk); #1 chk("fidle_busy", md_busy, 32'd0);
    flush = 1'b0; mulsel = 3'b000;
    #1 chk("badmsel_stall", md_stall, 32'd0);
    @(posedge clk); #1 chk("badmsel_busy", md_busy, 32'd0);
    mul_inst = 1'b0; div_inst = 1'b1; divsel = 3'b101;
    #1 chk("baddsel_stall", md_stall, 32'd0);
    @(posedge clk); #1 chk("baddsel_busy", md_busy, 32'd0);
    div_inst = 1'b0; divsel = 3'b000;

    // multiply variants
    run_op(1'b1, 1'b0, 3'b100, 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, lat, res, rdo, nst);
    chk("mulhu_res", res, 32'hFFFFFFFE);
    run_op(1'b1, 1'b0, 3'b011, 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, lat, res, rdo, nst);
    chk("mulhsu_res", res, 32'hFFFFFFFF);
    run_op(1'b1, 1'b0, 3'b010, 3'b000, 32'h80000000, 32'h80000000, 5'd8, lat, res, rdo, nst);
    chk("mulh_res", res, 32'h40000000);
    run_op(1'b1, 1'b1, 3'b001, 3'b001, 32'd7, 32'd2, 5'd3, lat, res, rdo, nst);
    chk("both_mul_res", res, 32'd14);
    chk("both_mul_lat", lat, 32'd3);

    // divide variants
    run_op(1'b0, 1'b1, 3'b000, 3'b001, 32'hFFFFFFF9, 32'd2, 5'd10, lat, res, rdo, nst);
    chk("div_res", res, 32'hFFFFFFFD);
    chk("div_lat", lat, 32'd33);
    chk("div_rd", rdo, 32'd10);
    chk("div_stall_cycles", nst, 32'd33);
    run_op(1'b0, 1'b1, 3'b000, 3'b011, 32'hFFFFFFF9, 32'd2, 5'd11, lat, res, rdo, nst);
    chk("rem_res", res, 32'hFFFFFFFF);
    run_op(1'b0, 1'b1, 3'b000, 3'b011, 32'd7, 32'hFFFFFFFE, 5'd12, lat, res, rdo, nst);
    chk("rem_pos_res", res, 32'd1);
    run_op(1'b0, 1'b1, 3'b000, 3'b001, 32'd7, 32'hFFFFFFFE, 5'd12, lat, res, rdo, nst);
    chk("div_negdiv_res", res, 32'hFFFFFFFD);
    run_op(1'b0, 1'b1, 3'b000, 3'b010, 32'hFFFFFFFF, 32'd16, 5'd13, lat, res, rdo, nst);
    chk("divu_res", res, 32'h0FFFFFFF);
    run_op(1'b0, 1'b1, 3'b000, 3'b100, 32'hFFFFFFFF, 32'd16, 5'd13, lat, res, rdo, nst);
    chk("remu_res", res, 32'h0000000F);
    run_op(1'b0, 1'b1, 3'b000, 3'b010, 32'd100, 32'd0, 5'd14, lat, res, rdo, nst);
    chk("divu0_res", res, 32'hFFFFFFFF);
    chk("divu0_lat", lat, 32'd1);
    run_op(1'b0, 1'b1, 3'b000, 3'b100, 32'd100, 32'd0, 5'd15, lat, res, rdo, nst);
    chk("remu0_res", res, 32'd100);
    chk("remu0_lat", lat, 32'd1);
    run_op(1'b0, 1'b1, 3'b000, 3'b001, 32'h80000000, 32'hFFFFFFFF, 5'd16, lat, res, rdo, nst);
    chk("ovf_div_res", res, 32'h80000000);
    chk("ovf_div_lat", lat, 32'd1);
    run_op(1'b0, 1'b1, 3'b000, 3'b011, 32'h80000000, 32'hFFFFFFFF, 5'd17, lat, res, rdo, nst);
    chk("ovf_rem_res", res, 32'd0);
    chk("ovf_rem_lat", lat, 32'd1);
    run_op(1'b0, 1'b1, 3'b000, 3'b001, 32'd3, 32'd5, 5'd18, lat, res, rdo, nst);
    chk("small_div_res", res, 32'd0);
    chk("small_div_lat", lat, SMALL_DIV_LAT);
    run_op(1'b0, 1'b1, 3'b000, 3'b011, 32'd3, 32'd5, 5'd18, lat, res, rdo, nst);
    chk("small_rem_res", res, 32'd3);

    // flush at cycle 10 of a div
    div_inst = 1'b1; divsel = 3'b001; rs1_data = 32'd100; rs2_data = 32'd7; rd_in = 5'd20;
    #1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    flush = 1'b1; div_inst = 1'b0; divsel = 3'b000;
    #1 chk("fdiv_busy10", md_busy, 32'd1);
    @(posedge clk); #1 flush = 1'b0;
    chk("fdiv_busy11", md_busy, 32'd0);
    chk("fdiv_stall11", md_stall, 32'd0);
    chk("fdiv_valid11", md_result_valid, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (md_result_valid) pulses++;
    end
    chk("fdiv_no_pulse", pulses, 32'd0);
    run_op(1'b1, 1'b0, 3'b001, 3'b000, 32'd6, 32'd7, 5'd1, lat, res, rdo, nst);
    chk("post_flush_mul_res", res, 32'd42);
    chk("post_flush_mul_lat", lat, 32'd3);
    chk("post_flush_hold", md_result, 32'd42);

    // reset in the middle of a div
    div_inst = 1'b1; divsel = 3'b001; rs1_data = 32'd100; rs2_data = 32'd7; rd_in = 5'd21;
    #1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0; div_inst = 1'b0; divsel = 3'b000;
    #1;
    chk("mrst_result", md_result, 32'd0);
    chk("mrst_rd", md_rd, 32'd0);
    chk("mrst_busy", md_busy, 32'd0);
    chk("mrst_stall", md_stall, 32'd0);
    chk("mrst_valid", md_result_valid, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (md_result_valid) pulses++;
    end
    chk("mrst_no_pulse", pulses, 32'd0);
    chk("mrst_result_after", md_result, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
